demux14_stream: RTL and testbench
=================================

DEMUX14_STREAM -- requirements
Module: demux14_stream

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameter DATA_W, default 2: width of one data word.
REQ-003 Parameter CNT_W, default 8: width of each per-lane transfer counter (used only with DEMUX14_COUNT_EN).
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port reset, input, 1: asynchronous active-high reset.
REQ-006 Port in_valid, input, 1: upstream word present.
REQ-007 Port in_ready, output, 1: block accepts the word this cycle.
REQ-008 Port in_data, input, DATA_W: upstream word.
REQ-009 Port in_sel, input, 2: destination lane (0=A, 1=B, 2=C, 3=D).
REQ-010 Port out_valid, output, 4: bit i set means lane i holds a word.
REQ-011 Port out_ready, input, 4: bit i set means the lane i consumer takes the word.
REQ-012 Port out_data, output, 4*DATA_W: lane i occupies bits [i*DATA_W +: DATA_W].
REQ-013 Port xfer_count, output, 4*CNT_W: per-lane accepted-word counters; present only with DEMUX14_COUNT_EN.

Function
REQ-014 Each lane SHALL be a single-entry buffer with two states, EMPTY and FULL; out_valid[i] equals (lane i == FULL).
REQ-015 in_ready SHALL be the combinational value (lane[in_sel] EMPTY) | out_ready[in_sel].
REQ-016 An accept SHALL occur when in_valid & in_ready; on the next clk edge, lane in_sel loads in_data and goes FULL.
REQ-017 Latency SHALL be one cycle: a word accepted at edge N appears on out_data/out_valid after edge N.
REQ-018 A drain on lane i SHALL occur when out_valid[i] & out_ready[i]; lane i goes EMPTY unless it is loaded in the same cycle.
REQ-019 A simultaneous drain and accept on the same lane SHALL load the new word and leave the lane FULL, with no bubble.
REQ-020 Lanes SHALL drain independently and concurrently; a full, stalled lane SHALL NOT block accepts to other lanes.
REQ-021 While out_valid[i] & ~out_ready[i], out_data lane i SHALL hold stable.
REQ-022 When in_valid is 0, in_sel and in_data SHALL have no effect on state.
REQ-023 out_data of an EMPTY lane SHALL retain its last loaded value; after reset it is 0.

Reset
REQ-024 Asserting reset SHALL immediately force all lanes EMPTY, out_valid=4'b0000, out_data=0, and xfer_count=0.
REQ-025 Reset asserted mid-transfer SHALL discard all buffered words; the first accept after deassertion behaves as from an empty block.
REQ-026 While reset is high, in_ready SHALL follow REQ-015 with all lanes EMPTY, but no state SHALL change.

Configuration
REQ-027 With macro DEMUX14_COUNT_EN defined, each lane SHALL keep a CNT_W-bit counter that increments on every accept to that lane and wraps from 2^CNT_W-1 to 0.
REQ-028 Without DEMUX14_COUNT_EN, the xfer_count port and the counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-029 Package demux14_pkg SHALL hold NUM_LANES=4, SEL_W=2, the lane index constants LANE_A..LANE_D, and the lane state enum {EMPTY, FULL}.
REQ-030 Sub-module demux14_lane SHALL implement one single-entry buffer (state, data register, load/drain logic, optional counter), instantiated four times.

Verification
REQ-031 After reset, drive in_data=2'b01 to sel=0, 2'b00 to sel=1, 2'b11 to sel=2, and 2'b10 to sel=3, with out_ready=4'b1111 -> each word appears on its lane one cycle after accept, and out_valid pulses per lane.
REQ-032 With out_ready=4'b0000, send 2'b11 to lane C, then a second word to lane C -> in_ready=0 on the second word, lane C holds 2'b11, and an accept to lane A still succeeds.
REQ-033 With lane B FULL holding 2'b01, assert out_ready[1]=1 and in_valid with in_data=2'b10, sel=1 in the same cycle -> in_ready=1, lane B shows 2'b10 next cycle, and out_valid[1] stays 1.
REQ-034 Fill all four lanes, then assert reset mid-cycle asynchronously -> out_valid=0 and out_data=0 immediately, without waiting for clk.
REQ-035 With DEMUX14_COUNT_EN and CNT_W=8, send 257 words to lane D -> xfer_count lane D reads 1; other lanes read 0.

Source files
------------

// File: rtl/demux14_pkg.sv
// Shared constants and lane state type for the 1-to-4 stream demultiplexer.
package demux14_pkg;

   localparam int NUM_LANES = 4;
   localparam int SEL_W     = 2;

   localparam logic [SEL_W-1:0] LANE_A = 2'd0;
   localparam logic [SEL_W-1:0] LANE_B = 2'd1;
   localparam logic [SEL_W-1:0] LANE_C = 2'd2;
   localparam logic [SEL_W-1:0] LANE_D = 2'd3;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } laneStateT;

endpackage

// File: rtl/demux14_lane.sv
// One single-entry output lane: EMPTY/FULL state, data register and, with
// DEMUX14_COUNT_EN defined, a wrapping count of words loaded into the lane.
module demux14_lane
   import demux14_pkg::*;
#(
   parameter int DATA_W = 2,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [DATA_W-1:0] loadData,
   input  logic              drainReady,
   output laneStateT         laneState,
   output logic [DATA_W-1:0] laneData
`ifdef DEMUX14_COUNT_EN
   ,
   output logic [CNT_W-1:0]  xferCount
`endif
);

   laneStateT stateNext;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         laneState <= EMPTY;
      end else begin
         laneState <= stateNext;
      end
   end

   // A load in the same cycle as a drain keeps the lane FULL with no bubble.
   always_comb begin
      stateNext = laneState;
      case (laneState)
         EMPTY: if (load) stateNext = FULL;
         FULL:  if (drainReady && !load) stateNext = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         laneData <= '0;
      end else if (load) begin
         laneData <= loadData;
      end
   end

`ifdef DEMUX14_COUNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         xferCount <= '0;
      end else if (load) begin
         xferCount <= xferCount + CNT_W'(1);
      end
   end
`endif

endmodule

// File: rtl/demux14_stream.sv
// 1-to-4 valid/ready stream demultiplexer with one single-entry buffer per lane.
// Optional per-lane accept counters are compiled in with DEMUX14_COUNT_EN.
module demux14_stream
   import demux14_pkg::*;
#(
   parameter int DATA_W = 2,
   parameter int CNT_W  = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [DATA_W-1:0]           in_data,
   input  logic [SEL_W-1:0]            in_sel,
   output logic [NUM_LANES-1:0]        out_valid,
   input  logic [NUM_LANES-1:0]        out_ready,
   output logic [NUM_LANES*DATA_W-1:0] out_data
`ifdef DEMUX14_COUNT_EN
   ,
   output logic [NUM_LANES*CNT_W-1:0]  xfer_count
`endif
);

   // Handshake: a word moves on a rising edge only when valid and ready are both
   // high in the preceding cycle; valid never waits on ready, and a lane holds
   // its valid and data stable until its consumer raises ready.

   if (CNT_W < 1) begin : gBadCntW
      $error("CNT_W must be at least 1");
   end

   laneStateT             laneState [NUM_LANES];
   logic [NUM_LANES-1:0]  laneFull;
   logic [NUM_LANES-1:0]  laneLoad;
   logic                  accept;

   // A full lane can still take a word if its consumer drains it this cycle.
   assign in_ready  = ~laneFull[in_sel] | out_ready[in_sel];
   assign accept    = in_valid & in_ready;
   assign out_valid = laneFull;

   for (genvar i = 0; i < NUM_LANES; i++) begin : gLane
      assign laneLoad[i] = accept && (in_sel == SEL_W'(i));
      assign laneFull[i] = (laneState[i] == FULL);

      demux14_lane #(
         .DATA_W (DATA_W),
         .CNT_W  (CNT_W)
      ) uLane (
         .clk        (clk),
         .reset      (reset),
         .load       (laneLoad[i]),
         .loadData   (in_data),
         .drainReady (out_ready[i]),
         .laneState  (laneState[i]),
         .laneData   (out_data[i*DATA_W +: DATA_W])
`ifdef DEMUX14_COUNT_EN
         ,
         .xferCount  (xfer_count[i*CNT_W +: CNT_W])
`endif
      );
   end

endmodule

// File: tb/tb_demux14_stream.sv
// Self-checking bench for demux14_stream: directed scenarios plus random
// traffic, all compared against a lane-array reference model.
module tb_demux14_stream;

   localparam int DATA_W = 2;
   localparam int CNT_W  = 8;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 in_valid;
   logic                 in_ready;
   logic [DATA_W-1:0]    in_data;
   logic [1:0]           in_sel;
   logic [3:0]           out_valid;
   logic [3:0]           out_ready;
   logic [4*DATA_W-1:0]  out_data;
`ifdef DEMUX14_COUNT_EN
   logic [4*CNT_W-1:0]   xfer_count;
`endif

   demux14_stream #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data)
`ifdef DEMUX14_COUNT_EN
      ,
      .xfer_count (xfer_count)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: what each lane holds and how many words it has taken.
   logic              mFull [4];
   logic [DATA_W-1:0] mData [4];
   int unsigned       mCnt  [4];

   int testsRun    = 0;
   int testsFailed = 0;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clearModel();
      for (int i = 0; i < 4; i++) begin
         mFull[i] = 1'b0;
         mData[i] = '0;
         mCnt[i]  = 0;
      end
   endtask

   task automatic checkOutputs(input string tag);
      logic [3:0]          expValid;
      logic [4*DATA_W-1:0] expData;
      for (int i = 0; i < 4; i++) begin
         expValid[i] = mFull[i];
         expData[i*DATA_W +: DATA_W] = mData[i];
      end
      checkVal({tag, "_out_valid"}, 32'(out_valid), 32'(expValid));
      checkVal({tag, "_out_data"}, 32'(out_data), 32'(expData));
`ifdef DEMUX14_COUNT_EN
      for (int i = 0; i < 4; i++)
         checkVal({tag, "_xfer_count"}, 32'(xfer_count[i*CNT_W +: CNT_W]),
                  32'(mCnt[i] % (1 << CNT_W)));
`endif
   endtask

   // Drive one cycle from just after an edge, check, then advance the model.
   task automatic cycle(input string tag, input logic v, input logic [1:0] sel,
                        input logic [DATA_W-1:0] d, input logic [3:0] ordy);
      logic expReady;
      in_valid  = v;
      in_sel    = sel;
      in_data   = d;
      out_ready = ordy;
      #1;
      expReady = !mFull[sel] || ordy[sel];
      checkVal({tag, "_in_ready"}, 32'(in_ready), 32'(expReady));
      checkOutputs(tag);
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         if (v && expReady && sel == 2'(i)) begin
            mFull[i] = 1'b1;
            mData[i] = d;
            mCnt[i]++;
         end else if (mFull[i] && ordy[i]) begin
            mFull[i] = 1'b0;
         end
      end
      #1;
   endtask

   task automatic applyReset();
      @(negedge clk);
      reset    = 1'b1;
      in_valid = 1'b0;
      clearModel();
      #1;
      checkOutputs("reset");
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_sel    = '0;
      out_ready = '0;
      clearModel();
      #2;
      checkOutputs("por");
      checkVal("por_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // One word per lane with every consumer ready: one-cycle valid pulses.
      cycle("d31_a", 1'b1, 2'd0, 2'b01, 4'b1111);
      checkVal("d31_a_seen", 32'(out_data[1:0]), 32'd1);
      cycle("d31_b", 1'b1, 2'd1, 2'b00, 4'b1111);
      cycle("d31_c", 1'b1, 2'd2, 2'b11, 4'b1111);
      checkVal("d31_c_seen", 32'(out_data[5:4]), 32'd3);
      cycle("d31_d", 1'b1, 2'd3, 2'b10, 4'b1111);
      checkVal("d31_d_valid", 32'(out_valid), 32'b1000);
      cycle("d31_idle", 1'b0, 2'd0, 2'b00, 4'b1111);

      // Stalled lane C refuses a second word; lane A still accepts.
      cycle("d32_c1", 1'b1, 2'd2, 2'b11, 4'b0000);
      in_valid = 1'b1; in_sel = 2'd2; in_data = 2'b01; out_ready = 4'b0000;
      #1;
      checkVal("d32_c2_blocked", 32'(in_ready), 32'd0);
      cycle("d32_c2", 1'b1, 2'd2, 2'b01, 4'b0000);
      checkVal("d32_c_hold", 32'(out_data[5:4]), 32'd3);
      cycle("d32_a", 1'b1, 2'd0, 2'b10, 4'b0000);
      checkVal("d32_a_valid", 32'(out_valid[0]), 32'd1);
      checkVal("d32_a_data", 32'(out_data[1:0]), 32'd2);

      // Same-cycle drain and load on lane B: no bubble.
      cycle("d33_load", 1'b1, 2'd1, 2'b01, 4'b0000);
      cycle("d33_swap", 1'b1, 2'd1, 2'b10, 4'b0010);
      checkVal("d33_b_data", 32'(out_data[3:2]), 32'd2);
      checkVal("d33_b_valid", 32'(out_valid[1]), 32'd1);

      // All lanes full, then an asynchronous reset between clock edges.
      for (int i = 0; i < 4; i++)
         cycle("d34_fill", 1'b1, 2'(i), DATA_W'($urandom_range(0, 3)), 4'b0000);
      checkVal("d34_all_full", 32'(out_valid), 32'b1111);
      #3;
      reset = 1'b1;
      clearModel();
      #1;
      checkOutputs("d34_async");
      in_valid = 1'b1; in_sel = 2'd2; in_data = 2'b11; out_ready = 4'b0000;
      #1;
      checkVal("d34_rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      checkOutputs("d34_rst_hold");
      reset = 1'b0;
      cycle("d34_first", 1'b1, 2'd1, 2'b10, 4'b0000);
      checkOutputs("d34_after");

`ifdef DEMUX14_COUNT_EN
      // Lane D counter wraps after 256 accepts.
      applyReset();
      for (int n = 0; n < 257; n++)
         cycle("d35", 1'b1, 2'd3, DATA_W'($urandom_range(0, 3)), 4'b1111);
      checkVal("d35_cnt_d", 32'(xfer_count[3*CNT_W +: CNT_W]), 32'd1);
      checkVal("d35_cnt_a", 32'(xfer_count[0 +: CNT_W]), 32'd0);
      checkVal("d35_cnt_b", 32'(xfer_count[CNT_W +: CNT_W]), 32'd0);
      checkVal("d35_cnt_c", 32'(xfer_count[2*CNT_W +: CNT_W]), 32'd0);
`endif

      // Random traffic with occasional resets.
      applyReset();
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 99) == 0) applyReset();
         cycle("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               DATA_W'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      end
      checkOutputs("rand_end");

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
